rgb_decoder: RTL and testbench
==============================

Name: rgb_decoder

Overview:
- Receive-side counterpart of the switch-to-RGB encoder: samples a 3-bit RGB lamp drive and recovers the 2-bit colour index.
- Filters glitches, flags illegal codes, checks traffic-light sequence order and measures dwell time per colour.
- Sits between the lamp driver outputs and the monitoring/self-check logic of the traffic-light design.

Parameters:
- STABLE_CYCLES, 4, consecutive identical samples required before a code is accepted (legal range 1..255).
- DWELL_W, 16, width of the dwell counter.

Ports:
- clk_i  input  1  system clock, all logic on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- rgb_i  input  3  RGB code under observation ({R,G,B}).
- color_o  output  2  decoded colour index of the last accepted legal code.
- valid_o  output  1  high while a legal code is accepted (state LOCKED).
- illegal_o  output  1  high while an illegal code is accepted (state FAULT).
- change_o  output  1  one-cycle pulse when a new legal colour is accepted.
- seq_err_o  output  1  one-cycle pulse coincident with change_o when the transition is out of order.
- dwell_o  output  DWELL_W  clock cycles the current legal colour has been held.

Behaviour:
- Clock and reset: single clock clk_i; rst_i is synchronous, active-high.
- Reset values: color_o=WHITE (2'b00), valid_o=0, illegal_o=0, change_o=0, seq_err_o=0, dwell_o=0. FSM=IDLE. Input sample register and stability counter cleared.
- Reset mid-operation: all outputs and state return to reset values on that edge. No pulse is emitted on reset exit.
- Code map (legal):
  - 3'b111 -> WHITE 2'b00
  - 3'b100 -> RED 2'b01
  - 3'b010 -> GREEN 2'b10
  - 3'b110 -> YELLOW 2'b11
  - All other codes (000, 001, 011, 101) are illegal.
- Input path: rgb_i is registered once. A run counter counts consecutive registered samples that are identical.
  - Any differing sample restarts the run at 1.
  - The counter saturates at STABLE_CYCLES.
- Acceptance: a code is accepted on the edge where its run reaches STABLE_CYCLES.
  - Latency from an rgb_i change (held stable) to the output update is exactly STABLE_CYCLES+1 edges.
  - Glitches shorter than STABLE_CYCLES samples never affect the outputs.
- FSM states:
  - IDLE: no accepted code since reset.
  - LOCKED: legal colour held.
  - FAULT: illegal code held.
- FSM transitions:
  - IDLE/FAULT/LOCKED + legal accepted, different from color_o or state not LOCKED -> LOCKED. color_o updates, change_o=1 for one cycle, dwell_o cleared to 0.
  - LOCKED + same colour re-accepted -> no change, no pulse.
  - any + illegal accepted -> FAULT. valid_o=0, illegal_o=1, color_o holds last value, dwell_o cleared and held at 0.
- Sequence check (LOCKED -> LOCKED only):
  - Allowed transitions: GREEN->YELLOW, YELLOW->RED, RED->GREEN, any->WHITE, WHITE->any.
  - Any other transition pulses seq_err_o together with change_o; the new colour is still accepted.
  - Entries from IDLE or FAULT are never checked.
- Dwell counter: increments by 1 every cycle in LOCKED after the change edge and saturates at all-ones. It stays 0 in IDLE and FAULT.
- valid_o and illegal_o are never both high.

Decomposition:
- Shared def include: colour index constants (WHITE/RED/GREEN/YELLOW) and RGB codes (WHITE_CODE etc.), the same ones the encoder uses. Add FSM state encodings IDLE=2'b00, LOCKED=2'b01, FAULT=2'b10.
- One natural sub-module: rgb_stabilizer. It holds the sample register and run counter and outputs the stable code plus an accept strobe. The FSM, sequence check and dwell counter stay in rgb_decoder.

Test Plan:
- Reset, then rgb_i=3'b010 held (STABLE_CYCLES=4) -> color_o=2'b10, valid_o=1 and change_o pulse exactly 5 edges after the change; seq_err_o=0.
- From GREEN, drive YELLOW 3'b110, then RED 3'b100, then GREEN -> three change_o pulses, seq_err_o never asserted, dwell_o restarts at 0 on each change.
- From GREEN, drive RED 3'b100 directly -> color_o=2'b01, change_o=1 and seq_err_o=1 on the same cycle.
- From RED, a 3-cycle glitch to 3'b010 then back to 3'b100 -> no output change, no pulses, dwell_o keeps counting.
- From LOCKED, hold 3'b101 for 4 samples -> illegal_o=1, valid_o=0, dwell_o=0, color_o unchanged. Then 3'b111 -> LOCKED WHITE, change_o=1, seq_err_o=0.
- With DWELL_W=4, hold GREEN for 20 cycles -> dwell_o saturates at 4'hF. Assert rst_i mid-hold -> all outputs at reset values on the next edge.

Source files
------------

// File: rtl/rgb_decoder_pkg.sv
// Shared definitions for the RGB lamp decoder.
// Holds the colour indices and lamp codes that the encoder also uses,
// the decoder FSM state encoding, and small decode/sequence helpers.
package rgb_decoder_pkg;

  // Colour indices as seen by the monitoring logic
  localparam logic [1:0] WHITE  = 2'b00;
  localparam logic [1:0] RED    = 2'b01;
  localparam logic [1:0] GREEN  = 2'b10;
  localparam logic [1:0] YELLOW = 2'b11;

  // Lamp drive codes, bit order {R,G,B}
  localparam logic [2:0] WHITE_CODE  = 3'b111;
  localparam logic [2:0] RED_CODE    = 3'b100;
  localparam logic [2:0] GREEN_CODE  = 3'b010;
  localparam logic [2:0] YELLOW_CODE = 3'b110;

  // Width of the stability run counter; large enough for any accepted filter depth
  localparam int unsigned RUN_W = 8;

  // Decoder FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LOCKED = 2'b01,
    FAULT  = 2'b10
  } state_t;

  // Result of decoding one lamp code
  typedef struct packed {
    logic       legal;
    logic [1:0] color;
  } decode_t;

  // Map a lamp code to its colour; anything outside the four lamp patterns is illegal
  function automatic decode_t decodeRgb(input logic [2:0] code);
    decode_t result;
    result.legal = 1'b1;
    result.color = WHITE;
    case (code)
      WHITE_CODE:  result.color = WHITE;
      RED_CODE:    result.color = RED;
      GREEN_CODE:  result.color = GREEN;
      YELLOW_CODE: result.color = YELLOW;
      default: begin
        result.legal = 1'b0;
        result.color = WHITE;
      end
    endcase
    return result;
  endfunction

  // Traffic-light order: GREEN->YELLOW->RED->GREEN, with WHITE reachable from
  // and leading to any colour
  function automatic logic seqAllowed(input logic [1:0] fromColor,
                                      input logic [1:0] toColor);
    logic ok;
    ok = 1'b0;
    if (toColor == WHITE || fromColor == WHITE) begin
      ok = 1'b1;
    end else begin
      case (fromColor)
        GREEN:   ok = (toColor == YELLOW);
        YELLOW:  ok = (toColor == RED);
        RED:     ok = (toColor == GREEN);
        default: ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/rgb_stabilizer.sv
// Glitch filter for the sampled lamp code.
// Registers the raw code once and counts how many consecutive registered
// samples have been identical. When that run first reaches STABLE_CYCLES a
// one-cycle accept strobe is raised together with the stable code.
module rgb_stabilizer
  import rgb_decoder_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [2:0] i_rgb,
  output logic [2:0] o_code,
  output logic       o_accept
);

  localparam logic [RUN_W-1:0] RUN_TARGET = RUN_W'(STABLE_CYCLES);
  localparam logic [RUN_W-1:0] RUN_ONE    = RUN_W'(1);

  logic [2:0]       r_sample;
  logic [RUN_W-1:0] r_run;
  logic [2:0]       r_code;
  logic             r_accept;

  logic             w_differ;
  logic [RUN_W-1:0] w_runNext;
  logic             w_reach;

  // Next run length: restart at 1 on a new code, otherwise count up and hold
  // at the target. The strobe fires only on the edge the target is reached,
  // so a long steady code is accepted once rather than every cycle.
  always_comb begin
    w_differ  = (i_rgb != r_sample);
    w_runNext = r_run;
    if (w_differ) begin
      w_runNext = RUN_ONE;
    end else if (r_run != RUN_TARGET) begin
      w_runNext = r_run + RUN_ONE;
    end
    w_reach = (w_runNext == RUN_TARGET) && (w_differ || (r_run != RUN_TARGET));
  end

  // Sample register, run counter and registered accept strobe with its code
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sample <= 3'b000;
      r_run    <= '0;
      r_code   <= 3'b000;
      r_accept <= 1'b0;
    end else begin
      r_sample <= i_rgb;
      r_run    <= w_runNext;
      r_accept <= w_reach;
      if (w_reach) begin
        r_code <= i_rgb;
      end
    end
  end

  assign o_code   = r_code;
  assign o_accept = r_accept;

endmodule

// File: rtl/rgb_decoder.sv
// Receive-side RGB lamp decoder.
// Recovers the colour index from a filtered lamp code, tracks whether the
// lamps show a legal colour or an illegal pattern, flags out-of-order
// colour changes and measures how long the current colour has been shown.
module rgb_decoder
  import rgb_decoder_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned DWELL_W       = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [2:0]         rgb_i,
  output logic [1:0]         color_o,
  output logic               valid_o,
  output logic               illegal_o,
  output logic               change_o,
  output logic               seq_err_o,
  output logic [DWELL_W-1:0] dwell_o
);

  localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);

  logic [2:0]         w_code;
  logic               w_accept;
  decode_t            w_dec;
  logic               w_newColor;

  state_t             r_state;
  state_t             w_stateNext;

  logic [1:0]         r_color;
  logic               r_change;
  logic               r_seqErr;
  logic [DWELL_W-1:0] r_dwell;

  logic [1:0]         w_colorNext;
  logic               w_changeNext;
  logic               w_seqErrNext;
  logic [DWELL_W-1:0] w_dwellNext;

  rgb_stabilizer #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_stabilizer (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_rgb   (rgb_i),
    .o_code  (w_code),
    .o_accept(w_accept)
  );

  assign w_dec = decodeRgb(w_code);

  // A legal code counts as a new colour unless it repeats the colour already locked
  always_comb begin
    w_newColor = w_accept && w_dec.legal &&
                 ((r_state != LOCKED) || (w_dec.color != r_color));
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next state: every accepted code decides between LOCKED and FAULT
  always_comb begin
    w_stateNext = r_state;
    if (w_accept) begin
      w_stateNext = w_dec.legal ? LOCKED : FAULT;
    end
  end

  // Output decision: colour, pulses and dwell count for the coming cycle.
  // Only LOCKED->LOCKED changes are order-checked; entries from IDLE or FAULT
  // are trusted.
  always_comb begin
    w_colorNext  = r_color;
    w_changeNext = 1'b0;
    w_seqErrNext = 1'b0;
    w_dwellNext  = r_dwell;
    if (w_accept && !w_dec.legal) begin
      w_dwellNext = '0;
    end else if (w_newColor) begin
      w_colorNext  = w_dec.color;
      w_changeNext = 1'b1;
      w_seqErrNext = (r_state == LOCKED) && !seqAllowed(r_color, w_dec.color);
      w_dwellNext  = '0;
    end else if (r_state == LOCKED) begin
      if (r_dwell != '1) begin
        w_dwellNext = r_dwell + DWELL_ONE;
      end
    end else begin
      w_dwellNext = '0;
    end
  end

  // Output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_color  <= WHITE;
      r_change <= 1'b0;
      r_seqErr <= 1'b0;
      r_dwell  <= '0;
    end else begin
      r_color  <= w_colorNext;
      r_change <= w_changeNext;
      r_seqErr <= w_seqErrNext;
      r_dwell  <= w_dwellNext;
    end
  end

  assign color_o   = r_color;
  assign valid_o   = (r_state == LOCKED);
  assign illegal_o = (r_state == FAULT);
  assign change_o  = r_change;
  assign seq_err_o = r_seqErr;
  assign dwell_o   = r_dwell;

endmodule

// File: tb/tb_rgb_decoder.sv
// Directed testbench for rgb_decoder.
// Drives lamp codes on the falling edge, samples outputs on the falling edge
// and compares against hand-computed values. A second instance with a 4-bit
// dwell counter shares the inputs to observe dwell saturation.
module tb_rgb_decoder;

  logic        clk;
  logic        rst;
  logic [2:0]  rgb;

  logic [1:0]  color;
  logic        valid;
  logic        illegal;
  logic        change;
  logic        seqErr;
  logic [15:0] dwell;

  logic [1:0]  color4;
  logic        valid4;
  logic        illegal4;
  logic        change4;
  logic        seqErr4;
  logic [3:0]  dwell4;

  int testCount = 0;
  int failCount = 0;
  int pulseCount;

  rgb_decoder #(
    .STABLE_CYCLES(4),
    .DWELL_W      (16)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .rgb_i    (rgb),
    .color_o  (color),
    .valid_o  (valid),
    .illegal_o(illegal),
    .change_o (change),
    .seq_err_o(seqErr),
    .dwell_o  (dwell)
  );

  rgb_decoder #(
    .STABLE_CYCLES(4),
    .DWELL_W      (4)
  ) dut4 (
    .clk_i    (clk),
    .rst_i    (rst),
    .rgb_i    (rgb),
    .color_o  (color4),
    .valid_o  (valid4),
    .illegal_o(illegal4),
    .change_o (change4),
    .seq_err_o(seqErr4),
    .dwell_o  (dwell4)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count one comparison and report it if it does not match
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive a code from a falling edge and hold it for the given number of cycles
  task automatic applyStimulus(input logic [2:0] code, input int cycles);
    rgb = code;
    repeat (cycles) @(negedge clk);
  endtask

  // Drive a new legal code and check it lands exactly five edges later
  task automatic expectAccept(input string tag, input logic [2:0] code,
                              input logic [1:0] expColor, input logic expSeq);
    applyStimulus(code, 4);
    checkOutput({tag, "_early_change"}, 32'(change), 0);
    applyStimulus(code, 1);
    checkOutput({tag, "_color"},  32'(color),  32'(expColor));
    checkOutput({tag, "_valid"},  32'(valid),  1);
    checkOutput({tag, "_change"}, 32'(change), 1);
    checkOutput({tag, "_seqerr"}, 32'(seqErr), 32'(expSeq));
    checkOutput({tag, "_dwell"},  32'(dwell),  0);
  endtask

  initial begin
    rst = 1'b1;
    rgb = 3'b000;
    repeat (3) @(negedge clk);

    // Reset state
    checkOutput("rst_color",   32'(color),   0);
    checkOutput("rst_valid",   32'(valid),   0);
    checkOutput("rst_illegal", 32'(illegal), 0);
    checkOutput("rst_change",  32'(change),  0);
    checkOutput("rst_seqerr",  32'(seqErr),  0);
    checkOutput("rst_dwell",   32'(dwell),   0);
    checkOutput("rst_dwell4",  32'(dwell4),  0);

    // First GREEN from IDLE, with dwell counting afterwards
    rst = 1'b0;
    expectAccept("green0", 3'b010, 2'b10, 1'b0);
    applyStimulus(3'b010, 3);
    checkOutput("green0_pulse_end", 32'(change), 0);
    checkOutput("green0_dwell3",    32'(dwell),  3);

    // Legal order GREEN->YELLOW->RED->GREEN
    expectAccept("yellow", 3'b110, 2'b11, 1'b0);
    applyStimulus(3'b110, 2);
    checkOutput("yellow_dwell2", 32'(dwell), 2);
    expectAccept("red", 3'b100, 2'b01, 1'b0);
    applyStimulus(3'b100, 2);
    expectAccept("green1", 3'b010, 2'b10, 1'b0);
    applyStimulus(3'b010, 2);

    // Out-of-order GREEN->RED is accepted but flagged
    expectAccept("badseq", 3'b100, 2'b01, 1'b1);
    applyStimulus(3'b100, 2);
    checkOutput("badseq_pulse_end", 32'(seqErr), 0);
    checkOutput("badseq_dwell2",    32'(dwell),  2);

    // Three-sample glitch to GREEN while RED is shown is filtered out
    pulseCount = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(3'b010, 1);
      pulseCount += int'(change) + int'(seqErr);
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(3'b100, 1);
      pulseCount += int'(change) + int'(seqErr);
    end
    checkOutput("glitch_pulses", 32'(pulseCount), 0);
    checkOutput("glitch_color",  32'(color),      1);
    checkOutput("glitch_valid",  32'(valid),      1);
    checkOutput("glitch_dwell",  32'(dwell),      13);

    // Illegal 101 moves to FAULT, colour held, dwell forced to zero
    applyStimulus(3'b101, 4);
    checkOutput("illegal_early", 32'(illegal), 0);
    applyStimulus(3'b101, 1);
    checkOutput("illegal_flag",   32'(illegal), 1);
    checkOutput("illegal_valid",  32'(valid),   0);
    checkOutput("illegal_color",  32'(color),   1);
    checkOutput("illegal_dwell",  32'(dwell),   0);
    checkOutput("illegal_change", 32'(change),  0);
    applyStimulus(3'b101, 3);
    checkOutput("illegal_dwell_hold", 32'(dwell), 0);

    // Recovery to WHITE from FAULT is not order-checked
    expectAccept("white", 3'b111, 2'b00, 1'b0);
    checkOutput("white_illegal", 32'(illegal), 0);

    // WHITE->GREEN then a long hold saturates the narrow dwell counter
    expectAccept("green2", 3'b010, 2'b10, 1'b0);
    applyStimulus(3'b010, 20);
    checkOutput("sat_dwell16", 32'(dwell),  20);
    checkOutput("sat_dwell4",  32'(dwell4), 15);
    checkOutput("sat_color4",  32'(color4), 2);
    checkOutput("sat_valid4",  32'(valid4), 1);

    // Reset mid-hold returns everything to reset values on the next edge
    rst = 1'b1;
    applyStimulus(3'b010, 1);
    checkOutput("midrst_color",   32'(color),    0);
    checkOutput("midrst_valid",   32'(valid),    0);
    checkOutput("midrst_illegal", 32'(illegal),  0);
    checkOutput("midrst_change",  32'(change),   0);
    checkOutput("midrst_seqerr",  32'(seqErr),   0);
    checkOutput("midrst_dwell",   32'(dwell),    0);
    checkOutput("midrst_dwell4",  32'(dwell4),   0);
    checkOutput("midrst_illegal4", 32'(illegal4), 0);

    // No pulse on reset exit; the held code is re-accepted from IDLE
    rst = 1'b0;
    applyStimulus(3'b010, 1);
    checkOutput("exit_change", 32'(change), 0);
    checkOutput("exit_valid",  32'(valid),  0);
    applyStimulus(3'b010, 3);
    checkOutput("exit_valid_late", 32'(valid), 0);
    applyStimulus(3'b010, 1);
    checkOutput("exit_accept_valid",  32'(valid),   1);
    checkOutput("exit_accept_change", 32'(change),  1);
    checkOutput("exit_accept_seqerr", 32'(seqErr),  0);
    checkOutput("exit_accept_change4", 32'(change4), 1);
    checkOutput("exit_accept_seqerr4", 32'(seqErr4), 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
